// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Owner of the RAM port
  typedef enum logic {
    GR_CPU = 1'b0,
    GR_LD  = 1'b1
  } grant_t;

  // The requester that did not hold the previous grant
  function automatic grant_t other_grant(input grant_t g);
    grant_t r;
    if (g == GR_CPU) begin
      r = GR_LD;
    end else begin
      r = GR_CPU;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin choice between the CPU and the loader.
module rr_pick
  import ram_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic ld_req,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  // A lone requester wins outright; a tie goes to whoever was not granted last
  always_comb begin
    valid  = 1'b0;
    winner = GR_CPU;
    if (cpu_req && ld_req) begin
      valid  = 1'b1;
      winner = other_grant(grant_t'(last_grant));
    end else if (cpu_req) begin
      valid  = 1'b1;
      winner = GR_CPU;
    end else if (ld_req) begin
      valid  = 1'b1;
      winner = GR_LD;
    end else begin
      valid  = 1'b0;
      winner = GR_CPU;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the CPU and the button-driven loader.
// One transaction at a time: IDLE picks and latches the winner's request,
// ISSUE drives the RAM for one cycle, WAIT covers the registered read,
// DONE pulses the winner's ack (with read data for reads).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant
);

  arb_state_t        state;
  arb_state_t        next_state;
  grant_t            owner;
  grant_t            last_grant;
  logic              lat_we;

  logic              pick_valid;
  logic              pick_winner;
  logic              start_txn;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              ram_wren_d;
  logic              cpu_ack_d;
  logic              ld_ack_d;
  logic [DATA_W-1:0] cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_d;

  rr_pick u_pick (
    .cpu_req    (cpu_req),
    .ld_req     (ld_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign start_txn = (state == IDLE) && pick_valid;
  assign busy      = (state != IDLE);
  assign grant     = owner;

  // Route the winning requester's command fields toward the latch
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (pick_winner == GR_LD) begin
      sel_we    = ld_we;
      sel_addr  = ld_addr;
      sel_wdata = ld_wdata;
    end else begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: writes skip WAIT, reads need it for the RAM read latency
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          next_state = ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: begin
        if (lat_we) begin
          next_state = DONE;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the granted request so later input changes cannot disturb it;
  // ram_addr/ram_wdata are the latch itself and so stay stable in ISSUE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= GR_CPU;
      last_grant <= GR_LD;
      lat_we     <= 1'b0;
      ram_addr   <= {ADDR_W{1'b0}};
      ram_wdata  <= {DATA_W{1'b0}};
    end else if (start_txn) begin
      owner      <= grant_t'(pick_winner);
      last_grant <= grant_t'(pick_winner);
      lat_we     <= sel_we;
      ram_addr   <= sel_addr;
      ram_wdata  <= sel_wdata;
    end else begin
      owner      <= owner;
      last_grant <= last_grant;
      lat_we     <= lat_we;
      ram_addr   <= ram_addr;
      ram_wdata  <= ram_wdata;
    end
  end

  // Output next-values: write enable only for the ISSUE cycle, ack on DONE entry
  always_comb begin
    ram_wren_d  = 1'b0;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    cpu_rdata_d = cpu_rdata;
    ld_rdata_d  = ld_rdata;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          ram_wren_d = sel_we;
        end else begin
          ram_wren_d = 1'b0;
        end
      end
      ISSUE: begin
        if (lat_we) begin
          cpu_ack_d = (owner == GR_CPU);
          ld_ack_d  = (owner == GR_LD);
        end else begin
          cpu_ack_d = 1'b0;
          ld_ack_d  = 1'b0;
        end
      end
      WAIT: begin
        cpu_ack_d = (owner == GR_CPU);
        ld_ack_d  = (owner == GR_LD);
        if (owner == GR_LD) begin
          ld_rdata_d = ram_rdata;
        end else begin
          cpu_rdata_d = ram_rdata;
        end
      end
      DONE: begin
        ram_wren_d = 1'b0;
      end
      default: begin
        ram_wren_d = 1'b0;
      end
    endcase
  end

  // Registered outputs; reset clears ram_wren at once and drops any pending ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_wren  <= 1'b0;
      cpu_ack   <= 1'b0;
      ld_ack    <= 1'b0;
      cpu_rdata <= {DATA_W{1'b0}};
      ld_rdata  <= {DATA_W{1'b0}};
    end else begin
      ram_wren  <= ram_wren_d;
      cpu_ack   <= cpu_ack_d;
      ld_ack    <= ld_ack_d;
      cpu_rdata <= cpu_rdata_d;
      ld_rdata  <= ld_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a transaction-level reference model
// and a small RAM with one-cycle registered read.
module tb_ram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, ld_req, ld_we;
  logic [AW-1:0] cpu_addr, ld_addr;
  logic [DW-1:0] cpu_wdata, ld_wdata;
  logic          cpu_ack, ld_ack;
  logic [DW-1:0] cpu_rdata, ld_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_rdata;
  logic          busy, grant;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
    .ram_rdata(ram_rdata), .busy(busy), .grant(grant)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM: location 0x20 preloaded with 0xC3, everything else 0
  bit [7:0] mem [256];
  bit       written [256];

  function automatic logic [7:0] ram_read(input logic [7:0] a);
    if (written[a]) return mem[a];
    else if (a == 8'h20) return 8'hC3;
    else return 8'h00;
  endfunction

  // RAM write port and registered read
  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_addr[7:0]]     <= ram_wdata;
      written[ram_addr[7:0]] <= 1'b1;
    end
    ram_rdata <= ram_read(ram_addr[7:0]);
  end

  // Reference model: a transaction occupies 'len' cycles after the grant edge
  // (2 for a write, 3 for a read); phase counts cycles since the grant.
  int            m_phase, m_len;
  bit            m_owner, m_last, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_cpu_rd, m_ld_rd;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_phase = 0; m_len = 2; m_owner = 1'b0; m_last = 1'b1; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_ld_rd = '0;
      end else if (m_phase == 0) begin
        if (cpu_req || ld_req) begin
          if (cpu_req && ld_req) m_owner = !m_last;
          else                   m_owner = ld_req;
          m_last  = m_owner;
          m_we    = m_owner ? ld_we : cpu_we;
          m_addr  = m_owner ? ld_addr : cpu_addr;
          m_wdata = m_owner ? ld_wdata : cpu_wdata;
          m_len   = m_we ? 2 : 3;
          m_phase = 1;
        end
      end else if (m_phase == m_len) begin
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
        if (m_phase == m_len && !m_we) begin
          if (m_owner) m_ld_rd = ram_read(m_addr[7:0]);
          else         m_cpu_rd = ram_read(m_addr[7:0]);
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("busy", busy, m_phase != 0);
        check("grant", grant, m_owner);
        check("ram_wren", ram_wren, (m_phase == 1) && m_we);
        if (m_phase == 1) begin
          check("ram_addr", ram_addr, m_addr);
          check("ram_wdata", ram_wdata, m_wdata);
        end
        check("cpu_ack", cpu_ack, (m_phase != 0) && (m_phase == m_len) && !m_owner);
        check("ld_ack", ld_ack, (m_phase != 0) && (m_phase == m_len) && m_owner);
        check("cpu_rdata", cpu_rdata, m_cpu_rd);
        check("ld_rdata", ld_rdata, m_ld_rd);
      end
    end
  end

  // Observation results
  int            ack_own[$];
  int            c_ack_at, l_ack_at, c_ack_n, l_ack_n, wren_n;
  logic [AW-1:0] wren_addr;
  logic [DW-1:0] wren_data, c_rd, l_rd;

  task automatic observe(input int ncyc, input bit drop);
    c_ack_at = -1; l_ack_at = -1; c_ack_n = 0; l_ack_n = 0; wren_n = 0;
    wren_addr = '0; wren_data = '0; c_rd = '0; l_rd = '0;
    ack_own.delete();
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (ram_wren) begin
        wren_n++; wren_addr = ram_addr; wren_data = ram_wdata;
      end
      if (cpu_ack) begin
        c_ack_n++; if (c_ack_at < 0) c_ack_at = i; c_rd = cpu_rdata;
        ack_own.push_back(0);
        if (drop) cpu_req = 1'b0;
      end
      if (ld_ack) begin
        l_ack_n++; if (l_ack_at < 0) l_ack_at = i; l_rd = ld_rdata;
        ack_own.push_back(1);
        if (drop) ld_req = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 1'b0;  ld_we = 1'b0;  ld_addr = '0;  ld_wdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_wren", ram_wren, 1'b0);
    check("rst_addr", ram_addr, 16'h0000);
    check("rst_wdata", ram_wdata, 8'h00);
    check("rst_acks", {cpu_ack, ld_ack}, 2'b00);
    check("rst_rdata", {cpu_rdata, ld_rdata}, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // CPU write 0x5A to 0x0010
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h5A;
    observe(6, 1'b1);
    check("w_wren_cycles", wren_n, 1);
    check("w_wren_addr", wren_addr, 16'h0010);
    check("w_wren_data", wren_data, 8'h5A);
    check("w_ack_latency", c_ack_at, 2);
    check("w_ack_count", c_ack_n, 1);
    check("w_mem", ram_read(8'h10), 8'h5A);

    // Loader read of 0x0020 (holds 0xC3)
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0020;
    observe(6, 1'b1);
    check("r_ack_latency", l_ack_at, 3);
    check("r_ack_count", l_ack_n, 1);
    check("r_rdata", l_rd, 8'hC3);
    check("r_cpu_ack_quiet", c_ack_n, 0);
    check("r_no_wren", wren_n, 0);

    // Simultaneous requests right after reset: CPU first, then loader
    do_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 8'h11;
    ld_req  = 1'b1; ld_we  = 1'b1; ld_addr  = 16'h0040; ld_wdata  = 8'h22;
    observe(8, 1'b1);
    check("tie_cpu_ack_at", c_ack_at, 2);
    check("tie_ld_ack_at", l_ack_at, 5);
    check("tie_ack_counts", {c_ack_n[7:0], l_ack_n[7:0]}, 16'h0101);

    // Both hold requests for six transactions: strict alternation
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0070; cpu_wdata = 8'hA1;
    ld_req  = 1'b1; ld_we  = 1'b1; ld_addr  = 16'h0071; ld_wdata  = 8'hB2;
    observe(18, 1'b0);
    cpu_req = 1'b0; ld_req = 1'b0;
    check("rr_count", ack_own.size(), 6);
    for (int k = 0; k < ack_own.size(); k++) check("rr_order", ack_own[k], k % 2);
    repeat (3) @(negedge clk);

    // Address/data changed during ISSUE do not reach the RAM
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h77;
    @(negedge clk);
    check("chg_issue_wren", ram_wren, 1'b1);
    check("chg_issue_addr", ram_addr, 16'h0010);
    cpu_addr = 16'h00FF; cpu_wdata = 8'hEE;
    observe(4, 1'b1);
    check("chg_ack_at", c_ack_at, 1);
    check("chg_mem_10", ram_read(8'h10), 8'h77);
    check("chg_mem_ff", ram_read(8'hFF), 8'h00);

    // Reset during ISSUE of a write (last grant was the CPU)
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 8'h99;
    @(negedge clk);
    check("ar_wren_before", ram_wren, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("ar_wren_async", ram_wren, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_ack", cpu_ack, 1'b0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    observe(3, 1'b0);
    check("ar_no_ack", c_ack_n, 0);
    check("ar_mem_50", ram_read(8'h50), 8'h00);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0060; cpu_wdata = 8'h01;
    ld_req  = 1'b1; ld_we  = 1'b1; ld_addr  = 16'h0061; ld_wdata  = 8'h02;
    observe(8, 1'b1);
    check("ar_tie_cpu_at", c_ack_at, 2);
    check("ar_tie_ld_at", l_ack_at, 5);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the RAM address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the RAM data width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 cpu_req  in  1  SHALL be the CPU access request, held until cpu_ack.
REQ-006 cpu_we  in  1  SHALL select write (1) or read (0) for the CPU access.
REQ-007 cpu_addr  in  ADDR_W  SHALL be the CPU access address.
REQ-008 cpu_wdata  in  DATA_W  SHALL be the CPU write data.
REQ-009 cpu_ack  out  1  SHALL be a one-cycle completion pulse to the CPU.
REQ-010 cpu_rdata  out  DATA_W  SHALL be the CPU read data, valid with cpu_ack on reads.
REQ-011 ld_req, ld_we, ld_addr, ld_wdata, ld_ack, ld_rdata SHALL mirror REQ-005..010 for the button-driven memory loader.
REQ-012 ram_addr  out  ADDR_W  SHALL be the registered RAM address.
REQ-013 ram_wdata  out  DATA_W  SHALL be the registered RAM write data.
REQ-014 ram_wren  out  1  SHALL be the registered RAM write enable.
REQ-015 ram_rdata  in  DATA_W  SHALL be the RAM read data; the RAM has a one-cycle registered read.
REQ-016 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-017 grant  out  1  SHALL identify the current owner: 0 = CPU, 1 = loader.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-019 In IDLE with at least one req high, the arbiter SHALL pick a winner and latch its we, addr and wdata, then go to ISSUE.
REQ-020 The winner SHALL be the sole requester; when both request, it SHALL be the one not granted last (round-robin).
REQ-021 last_grant SHALL update at each grant.
REQ-022 In ISSUE, ram_addr and ram_wdata SHALL carry the latched values, and ram_wren SHALL equal the latched we, for exactly one cycle.
REQ-023 From ISSUE, a write SHALL go to DONE and a read SHALL go to WAIT; WAIT SHALL go to DONE.
REQ-024 In DONE, the winner's ack SHALL be high for one cycle, and for reads its rdata SHALL hold the RAM data captured in WAIT.
REQ-025 DONE SHALL always return to IDLE.
REQ-026 Latency from req sampled in IDLE to ack SHALL be 2 cycles for a write and 3 cycles for a read.
REQ-027 ram_wren SHALL be 0 in every state except ISSUE with a latched write.
REQ-028 The non-granted requester's ack SHALL stay 0, and its rdata SHALL hold its previous value.
REQ-029 Inputs changing after the grant SHALL NOT affect the transaction in flight.
REQ-030 A req dropped mid-transaction SHALL NOT abort it; the access still completes and ack still pulses.
REQ-031 A requester holding req through its ack cycle SHALL be re-arbitrated in the next IDLE; a tie then goes to the other requester.
REQ-032 Address and data widths SHALL pass through unmodified, with no sign extension inside this block.

Reset
REQ-033 While rst is low, the block SHALL be in IDLE with ram_wren=0, ram_addr=0, ram_wdata=0, both acks=0, both rdata=0, busy=0 and grant=0.
REQ-034 On reset, last_grant SHALL be set to the loader, so the CPU wins the first tie.
REQ-035 Reset asserted mid-transaction SHALL drop ram_wren immediately (asynchronously) and discard the transaction with no ack.

Structure
REQ-036 Package ram_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT/DONE), the grant enum (GR_CPU/GR_LD) and the default width constants.
REQ-037 Sub-module rr_pick SHALL be combinational: inputs two reqs and last_grant; outputs valid and winner.

Verification
REQ-038 CPU write 0x5A to 0x0010, loader idle -> ram_wren high for exactly 1 cycle with addr 0x0010 and data 0x5A; cpu_ack 2 cycles after req.
REQ-039 Loader read of 0x0020 with the RAM holding 0xC3 -> ld_ack 3 cycles after req with ld_rdata=0xC3; cpu_ack stays 0.
REQ-040 Both request in the same cycle after reset -> CPU granted first, loader granted in the next IDLE; each ack fires once.
REQ-041 Both hold req continuously for 6 transactions -> grants alternate CPU, LD, CPU, LD, ...
REQ-042 rst low during ISSUE of a write -> ram_wren falls without waiting for a clock edge, no ack, state IDLE; the next tie goes to the CPU.
REQ-043 cpu_addr changed from 0x0010 to 0x00FF during ISSUE -> RAM sees 0x0010 and the transaction completes normally.
